mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Parametrised N-port arbiter that merges independent memory requesters (instruction fetch, data access, future prefetch/DMA ports) onto a single physical memory port. It sits between the pipeline's per-stage memory ports and the shared cache/memory. It generalises the fixed two-port (A = fetch, B = data) arrangement to `N_PORTS` channels with selectable fixed-priority or round-robin arbitration. Each request's command is captured when the request is granted, so the downstream port sees stable signals for the whole transaction.

## Interface
- `N_PORTS`, 2: number of requester channels (>= 1); port 0 has the highest fixed priority.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width (multiple of 8); mask width `MASK_W = DATA_W/8`.
- `RR_MODE`, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `read`  in  N_PORTS  per-port read request, held until that port's `resp`.
- `write`  in  N_PORTS  per-port write request, held until that port's `resp`.
- `wmask`  in  N_PORTS*MASK_W  per-port byte enables, port i at `[i*MASK_W +: MASK_W]`.
- `address`  in  N_PORTS*ADDR_W  per-port address, same packing.
- `wdata`  in  N_PORTS*DATA_W  per-port write data, same packing.
- `resp`  out  N_PORTS  one-cycle completion pulse, at most one bit set.
- `rdata`  out  DATA_W  read data; valid with any `resp` bit that ends a read.
- `mem_read`  out  1  downstream read strobe.
- `mem_write`  out  1  downstream write strobe.
- `mem_wmask`  out  MASK_W  downstream byte enables.
- `mem_address`  out  ADDR_W  downstream address.
- `mem_wdata`  out  DATA_W  downstream write data.
- `mem_resp`  in  1  downstream completion.
- `mem_rdata`  in  DATA_W  downstream read data.

## Operation
- **States.** The FSM has two states, IDLE and BUSY. Reset state is IDLE.
- **Request.** Port i is requesting when `read[i] | write[i]`. If both bits are set, the request is treated as a write and the read is ignored.
- **IDLE.** If any port is requesting, the arbiter:
  - selects a winner `g`;
  - latches `g`, the op type, and that port's address, wdata and wmask;
  - moves to BUSY at the next edge.
  - With no requests, it stays in IDLE.
- **Fixed mode.** The lowest-index requesting port wins.
- **RR mode.** The search starts at `last_grant + 1`, wraps modulo `N_PORTS`, and takes the first requesting port. `last_grant` updates to `g` on every grant and resets to `N_PORTS-1`, so port 0 wins first after reset.
- **BUSY.**
  - `mem_read = ~op_is_write`, `mem_write = op_is_write`.
  - `mem_address`, `mem_wdata` and `mem_wmask` come from the latched registers only. Later changes on requester inputs are ignored.
  - On `mem_resp`: `resp[g] = 1` combinationally in the same cycle, and the FSM returns to IDLE at the next edge.
- **Read data.** `rdata = mem_rdata` combinationally in all states; it is meaningful only with a read `resp`.
- **Requester duty.** A requester must deassert its request at the edge after `resp`. A request still asserted in the following IDLE cycle is treated as a new transaction.
- **Single port.** With `N_PORTS = 1`, the grant index register is 1 bit wide, held at 0.
- **Reset.**
  - Asserting `reset` at any time forces IDLE, `mem_read = mem_write = 0` and `resp = 0` immediately, with no edge needed.
  - An in-flight downstream access is abandoned; a late `mem_resp` arriving in IDLE is ignored.
  - Latched address/data/mask registers reset to 0; `last_grant` resets to `N_PORTS-1`.
- **`mem_resp` in IDLE.** Always ignored: no `resp` bit is set and there is no state change.

## Timing
- **Reset values.** `resp = 0`, `mem_read = 0`, `mem_write = 0`, `mem_address = 0`, `mem_wdata = 0`, `mem_wmask = 0`. `rdata` follows `mem_rdata`.
- **Grant latency.** A request present in cycle t (IDLE) causes `mem_read`/`mem_write` to assert in cycle t+1.
- **Completion.** `resp[g]` asserts in the same cycle as `mem_resp`.
- **Throughput.** There is at least one IDLE cycle between consecutive transactions. The minimum occupancy per transaction is 2 cycles when memory responds in its first BUSY cycle.
- **Simultaneous requests.** These are resolved only in IDLE. A new request arriving during BUSY waits without penalty.
- **Output stability.** Downstream strobes and data are registered and stable for the entire BUSY interval.

## Test plan
- **Single read.** Reset, then `read[0]=1`, `address[0]=0x0000_0040`; memory responds after 3 cycles with `mem_rdata=0xDEAD_BEEF`. Required:
  - `mem_read` high from cycle 1;
  - `resp=2'b01` with `rdata=0xDEAD_BEEF` in the `mem_resp` cycle;
  - FSM in IDLE after that edge.
- **Write capture.** `write[1]=1`, `wdata[1]=0x1234_5678`, `wmask[1]=4'b0011`; change `wdata[1]` to 0 during BUSY. Required: `mem_wdata` stays `0x1234_5678`, `mem_wmask` stays `4'b0011`, and `resp=2'b10`.
- **Round-robin fairness.** `RR_MODE=1`, `N_PORTS=4`, all four ports requesting continuously and each re-requesting after its `resp`. Required grant order: 0,1,2,3,0,1.
- **Fixed priority.** `RR_MODE=0`, ports 0 and 2 requesting continuously. Required: port 0 is granted every time and port 2 never is.
- **Reset mid-BUSY.** Assert `reset` 2 cycles into a write. Required:
  - `mem_write=0` within the same cycle;
  - a `mem_resp` pulse arriving after reset release produces no `resp`.
- **Read+write collision.** `read[0]=write[0]=1`. Required: `mem_write=1` and `mem_read=0`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port memory requester arbiter onto one memory port
// Fixed-priority or round-robin grant; the winner's command is latched for the whole access.
module mem_port_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_PORTS-1:0]           read,
  input  logic [N_PORTS-1:0]           write,
  input  logic [N_PORTS*(DATA_W/8)-1:0] wmask,
  input  logic [N_PORTS*ADDR_W-1:0]    address,
  input  logic [N_PORTS*DATA_W-1:0]    wdata,
  output logic [N_PORTS-1:0]           resp,
  output logic [DATA_W-1:0]            rdata,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [(DATA_W/8)-1:0]        mem_wmask,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_resp,
  input  logic [DATA_W-1:0]            mem_rdata
);
  localparam int MASK_W = DATA_W / 8;
  localparam int GW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;

  logic [N_PORTS-1:0] req;
  logic [GW-1:0]      grant, winner, idx;
  logic               found, grant_en, op_write;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr, addr_q;
  logic [DATA_W-1:0]  sel_wdata, wdata_q;
  logic [MASK_W-1:0]  sel_wmask, wmask_q;

  assign req = read | write;

  // grant doubles as last_grant: it resets to N_PORTS-1 so port 0 is searched first
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (RR_MODE) idx = GW'((int'(grant) + 1 + i) % N_PORTS);
      else         idx = GW'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    sel_write = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (winner == GW'(i)) begin
        sel_addr  = address[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_wmask = wmask[i*MASK_W +: MASK_W];
        sel_write = write[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_next = BUSY;
        grant_en   = 1'b1;
      end
      BUSY: if (mem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= GW'(N_PORTS - 1);
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else if (grant_en) begin
      grant    <= winner;
      op_write <= sel_write;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
      wmask_q  <= sel_wmask;
    end
  end

  assign mem_read    = (state == BUSY) && !op_write;
  assign mem_write   = (state == BUSY) && op_write;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign rdata       = mem_rdata;

  always_comb begin
    resp = '0;
    if (state == BUSY && mem_resp) resp[grant] = 1'b1;
  end
endmodule
